// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder sequencer.
// Computes {cout, sum} = a + b + cin with one external full adder, one bit per
// clock, LSB first. The adder is purely combinational outside this block: fa_s
// and fa_cout respond to fa_a/fa_b/fa_cin within the same cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; adder inputs forced low
// S_RUN  | one operand bit per cycle through the adder, sum shifts in
// S_DONE | one-cycle done pulse; sum/cout valid and held afterwards

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  // Counter wide enough to index WIDTH bits, never narrower than one bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             last_bit;
  logic [WIDTH-1:0] sum_shift;

  assign last_bit = (cnt_q == CNT_LAST);

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at LSB.
  // A one-bit result has nothing to shift, so it is just the adder output.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in S_IDLE, so no queuing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted op leaves no trace.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath next values: load on accepted start, shift one bit per RUN cycle.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      S_RUN: begin
        sum_d   = sum_shift;
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // Hold the counter on the final bit instead of letting it wrap.
        if (last_bit) begin
          cout_d = fa_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state; adder inputs only active during S_RUN.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    case (state_q)
      S_RUN: begin
        busy   = 1'b1;
        fa_a   = a_sh_q[0];
        fa_b   = b_sh_q[0];
        fa_cin = carry_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: WIDTH=8, 1 and 32 instances, each paired with
// a behavioural full adder. Expected results come from plain integer addition.

module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WIDTH=8 instance
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       fa_a8, fa_b8, fa_cin8, fa_s8, fa_cout8;

  // WIDTH=1 instance
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
  logic       fa_a1, fa_b1, fa_cin1, fa_s1, fa_cout1;

  // WIDTH=32 instance
  logic        start32, cin32, busy32, done32, cout32;
  logic [31:0] a32, b32, sum32;
  logic        fa_a32, fa_b32, fa_cin32, fa_s32, fa_cout32;

  int compared   = 0;
  int mismatched = 0;

  assign fa_s8     = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8  = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_s1     = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1  = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);
  assign fa_s32    = fa_a32 ^ fa_b32 ^ fa_cin32;
  assign fa_cout32 = (fa_a32 & fa_b32) | (fa_a32 & fa_cin32) | (fa_b32 & fa_cin32);

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_cout(fa_cout8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_s(fa_s1), .fa_cout(fa_cout1)
  );

  serial_add_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32), .cin(cin32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32),
    .fa_a(fa_a32), .fa_b(fa_b32), .fa_cin(fa_cin32), .fa_s(fa_s32), .fa_cout(fa_cout32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation, entered and left at a negedge while IDLE.
  // change_at > 0 scrambles the input pins after that RUN cycle.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int change_at, input int hold, input string tag);
    logic [8:0] exp;
    int ma, pc;
    exp = 9'(a) + 9'(b) + 9'(c);
    chk({tag, "_fa_idle"}, 64'({fa_a8, fa_b8, fa_cin8}), 64'(0));
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      ma = (1 << (i - 1)) - 1;
      pc = ((int'(a) & ma) + (int'(b) & ma) + int'(c)) >> (i - 1);
      chk({tag, "_busy"}, 64'(busy8), 64'(1));
      chk({tag, "_nodone"}, 64'(done8), 64'(0));
      chk({tag, "_fa_in"}, 64'({fa_a8, fa_b8, fa_cin8}),
          64'({a[i-1], b[i-1], pc[0]}));
      if (i == change_at) begin
        a8 = ~a; b8 = 8'($urandom); cin8 = ~c;
      end
      @(negedge clk);
    end
    chk({tag, "_done"}, 64'(done8), 64'(1));
    chk({tag, "_busy_done"}, 64'(busy8), 64'(0));
    chk({tag, "_fa_done"}, 64'({fa_a8, fa_b8, fa_cin8}), 64'(0));
    chk({tag, "_sum"}, 64'(sum8), 64'(exp[7:0]));
    chk({tag, "_cout"}, 64'(cout8), 64'(exp[8]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_done"}, 64'(done8), 64'(0));
      chk({tag, "_hold_sum"}, 64'({cout8, sum8}), 64'(exp));
    end
  endtask

  task automatic do_op1(input logic a, input logic b, input logic c, input string tag);
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(c);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    for (int cyc = 1; cyc <= 2; cyc++) begin
      chk({tag, "_busy"}, 64'(busy1), 64'(cyc == 1));
      chk({tag, "_done"}, 64'(done1), 64'(cyc == 2));
      if (cyc == 2) chk({tag, "_result"}, 64'({cout1, sum1}), 64'(exp));
      @(negedge clk);
    end
  endtask

  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input string tag);
    logic [32:0] exp;
    int done_cyc;
    exp = 33'(a) + 33'(b) + 33'(c);
    done_cyc = 0;
    a32 = a; b32 = b; cin32 = c; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done32 === 1'b1 && done_cyc == 0) begin
        done_cyc = cyc;
        chk({tag, "_result"}, 64'({cout32, sum32}), 64'(exp));
      end
      @(negedge clk);
    end
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(33));
  endtask

  initial begin
    int phase, seen;
    logic [7:0] ra, rb;

    reset = 1'b1;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    start32 = 0; a32 = 0; b32 = 0; cin32 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst8_outs", 64'({busy8, done8, cout8, sum8, fa_a8, fa_b8, fa_cin8}), 64'(0));
    chk("rst1_outs", 64'({busy1, done1, cout1, sum1, fa_a1, fa_b1, fa_cin1}), 64'(0));
    chk("rst32_outs", 64'({busy32, done32, cout32, sum32}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors; the first is held six cycles past done.
    do_op8(8'h05, 8'h03, 1'b0, 0, 6, "add05_03");
    do_op8(8'hFF, 8'h01, 1'b0, 0, 1, "addFF_01");
    do_op8(8'h00, 8'h00, 1'b1, 0, 1, "add00_cin");
    do_op8(8'hFF, 8'hFF, 1'b1, 0, 1, "addFF_FF_cin");
    do_op8(8'h05, 8'h03, 1'b0, 3, 1, "midrun_change");

    // start held high: accepted at edges 0, 10, 20 only.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    for (int cyc = 1; cyc <= 29; cyc++) begin
      @(negedge clk);
      phase = cyc % 10;
      chk("held_busy", 64'(busy8), 64'(phase >= 1 && phase <= 8));
      chk("held_done", 64'(done8), 64'(phase == 9));
      if (phase == 9) chk("held_result", 64'({cout8, sum8}), 64'(9'h030));
    end
    start8 = 1'b0;
    @(negedge clk);

    // Reset asserted in RUN cycle 4 aborts without a done pulse.
    a8 = 8'h05; b8 = 8'h03; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outs", 64'({busy8, done8, cout8, sum8, fa_a8, fa_b8, fa_cin8}), 64'(0));
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 === 1'b1) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'(0));
    do_op8(8'h05, 8'h03, 1'b0, 0, 1, "after_abort");

    // Randomized operands against integer addition.
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_op8(ra, rb, 1'($urandom), 0, 1, "rand8");
    end

    // WIDTH=1: every operand combination.
    for (int v = 0; v < 8; v++) begin
      do_op1(v[2], v[1], v[0], "w1");
    end

    // WIDTH=32 boundary and a few random sums.
    do_op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "w32_wrap");
    for (int n = 0; n < 3; n++) begin
      do_op32($urandom, $urandom, 1'($urandom), "w32_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
